// File: rtl/sdram_read.sv
// Read-side engine of the SDRAM controller: ACTIVE, BURST_NUM READ bursts, PRECHARGE, with refresh break.
// Define SDRAM_RD_AUTO_PRECHARGE_EN to close the row with READ auto-precharge instead of PRECHARGE.
module sdram_read #(
    parameter int BURST_LEN = 4,
    parameter int CAS_LAT   = 3,
    parameter int TRCD      = 2,
    parameter int TRP       = 2,
    parameter int BURST_NUM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ini_end,
    input  logic        rd_trig,
    input  logic        ref_req,
    input  logic        r_en,
    output logic        r_req,
    output logic        read_data_end,
    output logic        read_ref_break_end,
    output logic [17:0] read_cmd,
    input  logic [15:0] dq_in,
    output logic [15:0] rd_data,
    output logic        rd_data_vld
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_TRCD,
        S_READ,
        S_PRE,
        S_TRP
    } state_t;

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_ACT  = 4'b0011;
    localparam logic [3:0]  CMD_READ = 4'b0101;
    localparam logic [17:0] CMD_IDLE = 18'h3C000;
`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
    localparam int TRP_CYC = BURST_LEN + TRP;
`else
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam int TRP_CYC = TRP;
`endif
    localparam int BCW = $clog2(BURST_NUM + 1);
    localparam logic [7:0]     TRCD_LAST  = 8'(TRCD - 1);
    localparam logic [7:0]     SLOT_LAST  = 8'(BURST_LEN - 1);
    localparam logic [7:0]     TRP_LAST   = 8'(TRP_CYC - 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_NUM - 1);
    localparam logic [BCW-1:0] BURST_DONE = BCW'(BURST_NUM);

    state_t         state, state_nxt;
    logic [7:0]     cnt, cnt_nxt;
    logic           pending;
    logic [11:0]    row;
    logic [8:0]     col;
    logic [BCW-1:0] burst_cnt;
    logic [CAS_LAT:0] vld_pipe;
    logic           slot_end, last_burst, trp_end, done, stop_req;

`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
    // The auto-precharge bit rides on the READ itself, so the break decision is taken at slot start.
    logic brk;
    assign stop_req = brk;
`else
    assign stop_req = ref_req;
`endif

    assign slot_end   = (state == S_READ) && (cnt == SLOT_LAST);
    assign last_burst = (burst_cnt == BURST_LAST);
    assign trp_end    = (state == S_TRP) && (cnt == TRP_LAST);
    assign done       = trp_end && (burst_cnt == BURST_DONE);

    assign read_data_end      = done;
    assign read_ref_break_end = trp_end && !done;
    assign r_req              = pending && (state == S_IDLE);
    assign rd_data_vld        = vld_pipe[CAS_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 8'd1;
        read_cmd  = {CMD_NOP, 2'b00, 12'h000};
        case (state)
            S_IDLE: begin
                read_cmd = CMD_IDLE;
                cnt_nxt  = 8'd0;
                if (r_en && pending)
                    state_nxt = S_ACT;
            end
            S_ACT: begin
                read_cmd  = {CMD_ACT, 2'b00, row};
                cnt_nxt   = 8'd0;
                state_nxt = S_TRCD;
            end
            S_TRCD: begin
                if (cnt == TRCD_LAST) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (cnt == 8'd0) begin
                    read_cmd = {CMD_READ, 2'b00, 3'b000, col};
`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
                    read_cmd[10] = last_burst || ref_req;
`endif
                end
                if (slot_end) begin
                    cnt_nxt = 8'd0;
                    if (last_burst || stop_req)
`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
                        state_nxt = S_TRP;
`else
                        state_nxt = S_PRE;
`endif
                end
            end
            S_PRE: begin
`ifndef SDRAM_RD_AUTO_PRECHARGE_EN
                read_cmd = {CMD_PRE, 2'b00, 12'h400};
`endif
                cnt_nxt   = 8'd0;
                state_nxt = S_TRP;
            end
            S_TRP: begin
                if (trp_end) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                cnt_nxt   = 8'd0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Position bookkeeping survives a refresh break so the next grant resumes the same row/column.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            row       <= 12'd0;
            col       <= 9'd0;
            burst_cnt <= '0;
            vld_pipe  <= '0;
            rd_data   <= 16'd0;
`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
            brk       <= 1'b0;
`endif
        end else begin
            if (done)
                pending <= 1'b0;
            else if (rd_trig && ini_end)
                pending <= 1'b1;
            if (slot_end) begin
                col       <= col + 9'(BURST_LEN);
                burst_cnt <= burst_cnt + BCW'(1);
            end
            if (done) begin
                row       <= row + 12'd1;
                col       <= 9'd0;
                burst_cnt <= '0;
            end
`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
            if ((state == S_READ) && (cnt == 8'd0))
                brk <= ref_req;
`endif
            vld_pipe <= {vld_pipe[CAS_LAT-1:0], state == S_READ};
            rd_data  <= dq_in;
        end
    end

endmodule
